// File: rtl/cu_fetch_seq.sv
// Fetch/sequence controller: FETCH -> WAIT -> DECODE -> EXEC -> CHECK, with a trap state.
// Define CU_TIMEOUT_EN to enable the MFC wait timeout (trap_code 2).
module cu_fetch_seq #(
    parameter int          ADDR_W   = 32,
    parameter int unsigned PC_LIMIT = 508,
    parameter int unsigned TRAP_VEC = 0,
    parameter int          TIMEOUT  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFC,
    input  logic [31:0]       mem_data,
    input  logic              exec_done,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              annul,
    input  logic              trap_ack,
    output logic              MFA,
    output logic [ADDR_W-1:0] MAR,
    output logic [31:0]       IR,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] nPC,
    output logic [1:0]        op,
    output logic              dispatch_valid,
    output logic              trap,
    output logic [1:0]        trap_code
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("cu_fetch_seq: TIMEOUT must be >= 2");
    end

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(PC_LIMIT);
    localparam logic [ADDR_W-1:0] VEC   = ADDR_W'(TRAP_VEC);
    localparam logic [ADDR_W-1:0] FOUR  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] EIGHT = ADDR_W'(8);

    typedef enum logic [2:0] {
        S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_CHECK, S_TRAP
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx, npc_nx, mar_nx;
    logic [31:0]       ir_nx;
    logic              mfa_nx, dv_nx, trap_nx;
    logic [1:0]        code_nx;

`ifdef CU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt, cnt_nx;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) cnt <= '0;
        else        cnt <= cnt_nx;
    end
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state          <= S_FETCH;
            PC             <= '0;
            nPC            <= FOUR;
            MAR            <= '0;
            IR             <= '0;
            MFA            <= 1'b0;
            dispatch_valid <= 1'b0;
            trap           <= 1'b0;
            trap_code      <= 2'd0;
        end else begin
            state          <= state_nx;
            PC             <= pc_nx;
            nPC            <= npc_nx;
            MAR            <= mar_nx;
            IR             <= ir_nx;
            MFA            <= mfa_nx;
            dispatch_valid <= dv_nx;
            trap           <= trap_nx;
            trap_code      <= code_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = PC;
        npc_nx   = nPC;
        mar_nx   = MAR;
        ir_nx    = IR;
        mfa_nx   = MFA;
        dv_nx    = 1'b0;
        trap_nx  = trap;
        code_nx  = trap_code;
`ifdef CU_TIMEOUT_EN
        cnt_nx   = cnt;
`endif
        case (state)
            S_FETCH: begin
                mar_nx   = PC;
                mfa_nx   = 1'b1;
`ifdef CU_TIMEOUT_EN
                cnt_nx   = '0;
`endif
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                // dispatch_valid is raised with IR so it is high for the DECODE cycle
                if (MFC) begin
                    ir_nx    = mem_data;
                    mfa_nx   = 1'b0;
                    dv_nx    = 1'b1;
                    state_nx = S_DECODE;
                end
`ifdef CU_TIMEOUT_EN
                else if (cnt == CNT_LAST) begin
                    mfa_nx   = 1'b0;
                    trap_nx  = 1'b1;
                    code_nx  = 2'd2;
                    state_nx = S_TRAP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
`endif
            end
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                if (exec_done) begin
                    if (br_taken) begin
                        pc_nx  = nPC;
                        npc_nx = br_target;
                    end else if (annul) begin
                        pc_nx  = nPC + FOUR;
                        npc_nx = nPC + EIGHT;
                    end else begin
                        pc_nx  = nPC;
                        npc_nx = nPC + FOUR;
                    end
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                // misalignment outranks the limit check
                if (PC[1:0] != 2'b00) begin
                    trap_nx  = 1'b1;
                    code_nx  = 2'd3;
                    state_nx = S_TRAP;
                end else if (PC > LIMIT) begin
                    trap_nx  = 1'b1;
                    code_nx  = 2'd1;
                    state_nx = S_TRAP;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            S_TRAP: begin
                if (trap_ack) begin
                    pc_nx    = VEC;
                    npc_nx   = VEC + FOUR;
                    trap_nx  = 1'b0;
                    code_nx  = 2'd0;
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_FETCH;
        endcase
    end

    assign op = IR[31:30];

endmodule

// File: tb/tb_cu_fetch_seq.sv
// Randomized bench for cu_fetch_seq against a per-instruction PC/nPC reference model.
module tb_cu_fetch_seq;
    localparam int AW = 32;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          MFC = 1'b0;
    logic [31:0]   mem_data = '0;
    logic          exec_done = 1'b0;
    logic          br_taken = 1'b0;
    logic [AW-1:0] br_target = '0;
    logic          annul = 1'b0;
    logic          trap_ack = 1'b0;
    logic          MFA;
    logic [AW-1:0] MAR;
    logic [31:0]   IR;
    logic [AW-1:0] PC;
    logic [AW-1:0] nPC;
    logic [1:0]    op;
    logic          dispatch_valid;
    logic          trap;
    logic [1:0]    trap_code;

    cu_fetch_seq dut (
        .Clk(Clk), .Reset(Reset), .MFC(MFC), .mem_data(mem_data),
        .exec_done(exec_done), .br_taken(br_taken), .br_target(br_target),
        .annul(annul), .trap_ack(trap_ack), .MFA(MFA), .MAR(MAR), .IR(IR),
        .PC(PC), .nPC(nPC), .op(op), .dispatch_valid(dispatch_valid),
        .trap(trap), .trap_code(trap_code)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc, m_npc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 6))
            0: return 32'd512;
            1: return 32'h42;
            2: return 32'hFFFF_FFFC;
            3: return 32'h40;
            default: return {23'd0, 7'($urandom_range(0, 127)), 2'b00};
        endcase
    endfunction

    task automatic wait_mfa(output bit ok);
        int n = 0;
        while (MFA !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        ok = (MFA === 1'b1);
        if (!ok) chk("mfa_wait_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_one();
        bit ok;
        int d;
        logic [31:0] w, tgt;
        logic bt, an;
        logic [1:0] code;
        wait_mfa(ok);
        if (!ok) return;
        chk("mar", MAR, m_pc);
        d = $urandom_range(0, 3);
        repeat (d) begin
            @(negedge Clk);
            chk("mfa_hold", MFA, 1);
        end
        w = $urandom;
        MFC = 1'b1; mem_data = w;
        @(negedge Clk);
        MFC = 1'b0; mem_data = $urandom;
        chk("dispatch", dispatch_valid, 1);
        chk("ir", IR, w);
        chk("op", op, w[31:30]);
        chk("mfa_drop", MFA, 0);
        // exec_done while in DECODE must be ignored
        if ($urandom_range(0, 3) == 0) begin
            exec_done = 1'b1; br_taken = 1'b1; br_target = 32'h100;
        end
        @(negedge Clk);
        exec_done = 1'b0; br_taken = 1'b0;
        chk("dispatch_pulse", dispatch_valid, 0);
        chk("pc_hold", PC, m_pc);
        d = $urandom_range(0, 2);
        repeat (d) begin
            trap_ack = 1'($urandom_range(0, 1));
            MFC = 1'($urandom_range(0, 1));
            @(negedge Clk);
            trap_ack = 1'b0; MFC = 1'b0;
        end
        bt = ($urandom_range(0, 2) == 0);
        an = 1'($urandom_range(0, 1));
        tgt = pick_target();
        exec_done = 1'b1; br_taken = bt; annul = an; br_target = tgt;
        @(negedge Clk);
        exec_done = 1'b0; br_taken = 1'b0; annul = 1'b0; br_target = $urandom;
        if (bt) begin
            m_pc = m_npc; m_npc = tgt;
        end else if (an) begin
            m_pc = m_npc + 32'd4; m_npc = m_npc + 32'd8;
        end else begin
            m_pc = m_npc; m_npc = m_npc + 32'd4;
        end
        chk("pc", PC, m_pc);
        chk("npc", nPC, m_npc);
        code = (m_pc % 4 != 0) ? 2'd3 : (m_pc > 32'd508) ? 2'd1 : 2'd0;
        @(negedge Clk);
        chk("trap", trap, code != 0);
        chk("trap_code", trap_code, code);
        if (code != 0) begin
            d = $urandom_range(0, 3);
            repeat (d) begin
                @(negedge Clk);
                chk("trap_code_hold", trap_code, code);
            end
            trap_ack = 1'b1;
            @(negedge Clk);
            trap_ack = 1'b0;
            m_pc = 32'd0; m_npc = 32'd4;
            chk("pc_vec", PC, m_pc);
            chk("npc_vec", nPC, m_npc);
            chk("trap_clear", trap, 0);
        end
    endtask

    initial begin
        bit ok;
        #1 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_pc", PC, 0);
        chk("rst_npc", nPC, 4);
        chk("rst_mar", MAR, 0);
        chk("rst_ir", IR, 0);
        chk("rst_mfa", MFA, 0);
        chk("rst_dispatch", dispatch_valid, 0);
        chk("rst_trap", trap, 0);
        chk("rst_trap_code", trap_code, 0);
        Reset = 1'b1;
        m_pc = 32'd0; m_npc = 32'd4;

        for (int n = 0; n < 300; n++) run_one();

        // reset during WAIT abandons the fetch immediately
        wait_mfa(ok);
        #2 Reset = 1'b0;
        #1;
        chk("async_mfa", MFA, 0);
        chk("async_pc", PC, 0);
        chk("async_npc", nPC, 4);
        @(negedge Clk);
        Reset = 1'b1;
        m_pc = 32'd0; m_npc = 32'd4;
        for (int n = 0; n < 20; n++) run_one();

`ifdef CU_TIMEOUT_EN
        begin
            int n = 0;
            wait_mfa(ok);
            while (MFA === 1'b1 && n < 40) begin
                n++;
                @(negedge Clk);
            end
            chk("timeout_cycles", n, 16);
            chk("timeout_trap", trap, 1);
            chk("timeout_code", trap_code, 2);
            trap_ack = 1'b1;
            @(negedge Clk);
            trap_ack = 1'b0;
            m_pc = 32'd0; m_npc = 32'd4;
            chk("timeout_pc_vec", PC, m_pc);
            for (int k = 0; k < 5; k++) run_one();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
